// File: rtl/div4_pkg.sv
// Shared constants, state encoding and operand helpers for the 4-bit restoring divider.
// Used by signed_div4 and div4_trial_sub.
package div4_pkg;

    localparam int WIDTH = 4;
    localparam int ITERS = 4;

    localparam logic [1:0]       LAST_ITER = 2'(ITERS - 1);
    localparam logic [WIDTH-1:0] DIV0_QUOT = 4'b1111;
    localparam logic [WIDTH-1:0] MOST_NEG  = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Widened so that the magnitude of the most negative operand (8) still fits.
    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        magnitude = neg ? ({(WIDTH+1){1'b0}} - {v[WIDTH-1], v}) : {1'b0, v};
    endfunction

endpackage

// File: rtl/div4_trial_sub.sv
// Combinational 5-bit trial subtractor for one restoring-division step.
// Zero latency; no flow control.
module div4_trial_sub
    import div4_pkg::*;
(
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           nonneg
);

    logic [WIDTH+1:0] wide;

    assign wide   = {1'b0, a} - {1'b0, b};
    assign diff   = wide[WIDTH:0];
    assign nonneg = ~wide[WIDTH+1];

endmodule

// File: rtl/signed_div4.sv
// 4-bit restoring divider: done 5 cycles after start (1 cycle for divide-by-zero); start ignored while busy.
// Define SIGNED_DIV4_SIGNED_EN for two's-complement operands; default build is unsigned.
module signed_div4
    import div4_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             overflow
);

    state_t state, state_next;

    logic [WIDTH:0]   dvd_mag, dvs_mag, prem;
    logic [WIDTH:0]   in_dvd_mag, in_dvs_mag;
    logic [WIDTH:0]   shifted, diff;
    logic             dvd_neg, dvs_neg, in_dvd_neg, in_dvs_neg;
    logic             nonneg, zero_pend, accept, ovf_res;
    logic [1:0]       cnt;
    logic [WIDTH-1:0] quo_mag, dvd_low, dvd_raw, q_res, r_res;
    logic             unused_bits;

`ifdef SIGNED_DIV4_SIGNED_EN
    assign in_dvd_neg = dividend[WIDTH-1];
    assign in_dvs_neg = divisor[WIDTH-1];
    assign q_res      = (dvd_neg ^ dvs_neg) ? (4'd0 - quo_mag) : quo_mag;
    assign r_res      = dvd_neg ? (4'd0 - prem[WIDTH-1:0]) : prem[WIDTH-1:0];
    // Only -8 / -1 yields a magnitude-8 quotient that must stay positive.
    assign ovf_res    = (quo_mag == MOST_NEG) && !(dvd_neg ^ dvs_neg);
    assign unused_bits = ^{prem[WIDTH], dvd_mag[WIDTH]};
`else
    assign in_dvd_neg = 1'b0;
    assign in_dvs_neg = 1'b0;
    assign q_res      = quo_mag;
    assign r_res      = prem[WIDTH-1:0];
    assign ovf_res    = 1'b0;
    assign unused_bits = ^{prem[WIDTH], dvd_mag[WIDTH], dvs_neg};
`endif

    assign in_dvd_mag = magnitude(dividend, in_dvd_neg);
    assign in_dvs_mag = magnitude(divisor, in_dvs_neg);

    // Rebuilds the original dividend for the divide-by-zero result.
    assign dvd_raw = dvd_neg ? (4'd0 - dvd_mag[WIDTH-1:0]) : dvd_mag[WIDTH-1:0];
    assign dvd_low = dvd_mag[WIDTH-1:0];
    assign shifted = {prem[WIDTH-1:0], dvd_low[LAST_ITER - cnt]};
    assign accept  = (state == IDLE) && start && !zero_pend;

    div4_trial_sub u_trial_sub (
        .a      (shifted),
        .b      (dvs_mag),
        .diff   (diff),
        .nonneg (nonneg)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: if (accept && (divisor != '0)) state_next = CALC;
            CALC: begin
                busy = 1'b1;
                if (cnt == LAST_ITER) state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_mag   <= '0;
            dvs_mag   <= '0;
            dvd_neg   <= 1'b0;
            dvs_neg   <= 1'b0;
            cnt       <= '0;
            prem      <= '0;
            quo_mag   <= '0;
            zero_pend <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done      <= 1'b0;
            zero_pend <= 1'b0;
            if (accept) begin
                dvd_mag   <= in_dvd_mag;
                dvs_mag   <= in_dvs_mag;
                dvd_neg   <= in_dvd_neg;
                dvs_neg   <= in_dvs_neg;
                cnt       <= '0;
                prem      <= '0;
                quo_mag   <= '0;
                zero_pend <= (divisor == '0);
            end
            if (zero_pend) begin
                quotient  <= DIV0_QUOT;
                remainder <= dvd_raw;
                div_zero  <= 1'b1;
                overflow  <= 1'b0;
                done      <= 1'b1;
            end
            if (state == CALC) begin
                prem    <= nonneg ? diff : shifted;
                quo_mag <= {quo_mag[WIDTH-2:0], nonneg};
                cnt     <= cnt + 2'd1;
            end
            if (state == FIX) begin
                quotient  <= q_res;
                remainder <= r_res;
                div_zero  <= 1'b0;
                overflow  <= ovf_res;
                done      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_signed_div4.sv
// Directed bench for signed_div4; expectations follow SIGNED_DIV4_SIGNED_EN when it is defined.
`timescale 1ns/1ps
module tb_signed_div4;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [3:0] dividend, divisor;
    logic       busy, done, div_zero, overflow;
    logic [3:0] quotient, remainder;

    int checks   = 0;
    int failures = 0;
    logic       have_prev = 1'b0;
    logic [3:0] prev_q;

    signed_div4 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start one division, optionally pulse a competing start (6/3) at cycle inj, wait for done.
    task automatic run_div(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] exp_q, input logic [3:0] exp_r,
                           input logic exp_dz, input logic exp_ovf,
                           input int exp_lat, input int exp_busy, input int inj);
        int lat;
        int busy_cnt;
        lat = 0;
        busy_cnt = 0;
        start = 1'b1;
        dividend = a;
        divisor = b;
        step();
        start = 1'b0;
        if (have_prev) check({tag, "_hold_q"}, {4'h0, quotient}, {4'h0, prev_q});
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            if (lat == inj) begin
                start = 1'b1;
                dividend = 4'd6;
                divisor = 4'd3;
            end else begin
                start = 1'b0;
            end
            step();
            lat++;
        end
        start = 1'b0;
        check({tag, "_lat"}, 8'(lat), 8'(exp_lat));
        check({tag, "_busy"}, 8'(busy_cnt), 8'(exp_busy));
        check({tag, "_q"}, {4'h0, quotient}, {4'h0, exp_q});
        check({tag, "_r"}, {4'h0, remainder}, {4'h0, exp_r});
        check({tag, "_dz"}, {7'h0, div_zero}, {7'h0, exp_dz});
        check({tag, "_ovf"}, {7'h0, overflow}, {7'h0, exp_ovf});
        prev_q = exp_q;
        have_prev = 1'b1;
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        start = 1'b0;
        dividend = 4'd0;
        divisor = 4'd0;
        step();
        step();
        check("rst_busy", {7'h0, busy}, 8'h0);
        check("rst_done", {7'h0, done}, 8'h0);
        check("rst_q", {4'h0, quotient}, 8'h0);
        check("rst_r", {4'h0, remainder}, 8'h0);
        rst = 1'b0;

        run_div("d7_2_inj", 4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1'b0, 5, 5, 2);
        run_div("d6_3", 4'd6, 4'd3, 4'd2, 4'd0, 1'b0, 1'b0, 5, 5, -1);
`ifdef SIGNED_DIV4_SIGNED_EN
        run_div("dm7_2", 4'b1001, 4'd2, 4'b1101, 4'b1111, 1'b0, 1'b0, 5, 5, -1);
        run_div("d7_m2", 4'd7, 4'b1110, 4'b1101, 4'b0001, 1'b0, 1'b0, 5, 5, -1);
        run_div("d5_0", 4'd5, 4'd0, 4'b1111, 4'b0101, 1'b1, 1'b0, 1, 0, -1);
        run_div("dm8_m1", 4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 1'b1, 5, 5, -1);
        run_div("dm8_3", 4'b1000, 4'd3, 4'b1110, 4'b1110, 1'b0, 1'b0, 5, 5, -1);
        run_div("dm8_1", 4'b1000, 4'd1, 4'b1000, 4'b0000, 1'b0, 1'b0, 5, 5, -1);
`else
        run_div("d9_2", 4'b1001, 4'd2, 4'd4, 4'd1, 1'b0, 1'b0, 5, 5, -1);
        run_div("d7_14", 4'd7, 4'b1110, 4'd0, 4'd7, 1'b0, 1'b0, 5, 5, -1);
        run_div("d5_0", 4'd5, 4'd0, 4'b1111, 4'b0101, 1'b1, 1'b0, 1, 0, -1);
        run_div("d8_15", 4'b1000, 4'b1111, 4'd0, 4'd8, 1'b0, 1'b0, 5, 5, -1);
        run_div("d8_3", 4'b1000, 4'd3, 4'd2, 4'd2, 1'b0, 1'b0, 5, 5, -1);
        run_div("d8_1", 4'b1000, 4'd1, 4'd8, 4'd0, 1'b0, 1'b0, 5, 5, -1);
`endif

        // Reset lands on the edge that closes the third CALC cycle.
        start = 1'b1;
        dividend = 4'd7;
        divisor = 4'd2;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        start = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        check("mid_rst_busy", {7'h0, busy}, 8'h0);
        check("mid_rst_done", {7'h0, done}, 8'h0);
        check("mid_rst_q", {4'h0, quotient}, 8'h0);
        check("mid_rst_r", {4'h0, remainder}, 8'h0);
        check("mid_rst_flags", {6'h0, div_zero, overflow}, 8'h0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) seen++;
            step();
        end
        check("mid_rst_no_done", 8'(seen), 8'h0);
        have_prev = 1'b0;

`ifdef SIGNED_DIV4_SIGNED_EN
        run_div("d9_4", 4'd9, 4'd4, 4'b1111, 4'b1101, 1'b0, 1'b0, 5, 5, -1);
`else
        run_div("d9_4", 4'd9, 4'd4, 4'd2, 4'd1, 1'b0, 1'b0, 5, 5, -1);
`endif
        step();
        check("done_one_cycle", {7'h0, done}, 8'h0);
        check("hold_after_done_q", {4'h0, quotient}, {4'h0, prev_q});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/signed_div4.md
SIGNED_DIV4 -- requirements
Module: signed_div4

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have rst, input, 1, synchronous, active-high reset sampled on the clk rising edge.
REQ-003 SHALL have start, input, 1, request a division; sampled only in IDLE.
REQ-004 SHALL have dividend, input, 4, two's-complement dividend.
REQ-005 SHALL have divisor, input, 4, two's-complement divisor.
REQ-006 SHALL have busy, output, 1, high while in CALC or FIX.
REQ-007 SHALL have done, output, 1, single-cycle pulse marking that the result outputs are valid.
REQ-008 SHALL have quotient, output, 4, two's-complement quotient, truncated toward zero.
REQ-009 SHALL have remainder, output, 4, two's-complement remainder, same sign as the dividend.
REQ-010 SHALL have div_zero, output, 1, result was produced with divisor == 0.
REQ-011 SHALL have overflow, output, 1, true quotient not representable in 4 bits.

Function
REQ-012 SHALL implement states IDLE, CALC, FIX: IDLE->CALC on start (divisor != 0); CALC->FIX after 4 iterations; FIX->IDLE unconditionally.
REQ-013 SHALL, at the accepting edge, register the dividend magnitude (5-bit, so -8 -> 8), the divisor magnitude and both sign bits, and clear the 2-bit iteration counter and the partial remainder.
REQ-014 SHALL perform one restoring iteration per CALC cycle, MSB first: shift the partial remainder left with the next dividend bit, trial-subtract the divisor magnitude (5-bit), keep the difference and set the quotient bit to 1 if non-negative, else restore and set it to 0.
REQ-015 SHALL, in FIX, negate the quotient if the operand signs differ and negate the remainder if the dividend is negative, then register the outputs and assert done.
REQ-016 SHALL assert done exactly 5 clk cycles after the start-accepting edge for a non-zero divisor; done SHALL be high for one cycle only.
REQ-017 SHALL, for divisor == 0, go IDLE->IDLE and, on the next edge, pulse done with div_zero=1, quotient=4'b1111, remainder=dividend, and overflow=0.
REQ-018 SHALL, for dividend=-8 and divisor=-1, produce quotient=4'b1000, remainder=0, and overflow=1.
REQ-019 SHALL ignore start while busy=1; the operands of an in-flight operation SHALL NOT change.
REQ-020 SHALL hold quotient, remainder, div_zero and overflow stable from done until the next done.
REQ-021 SHALL accept start in the cycle directly after done, with no idle gap required.

Reset
REQ-022 SHALL, on rst, force state IDLE and clear busy, done, quotient, remainder, div_zero, overflow and all internal registers to 0.
REQ-023 SHALL, if rst is asserted mid-operation, abandon the operation with no done pulse; rst SHALL take priority over start in the same cycle.

Configuration
REQ-024 SHALL support macro SIGNED_DIV4_SIGNED_EN: when defined, operands, quotient and remainder are two's complement as specified above.
REQ-025 SHALL, without SIGNED_DIV4_SIGNED_EN, treat the operands as unsigned and skip the negations in FIX, keeping the FIX cycle so latency stays 5; overflow SHALL then be tied to 0, and the divide-by-zero result SHALL be quotient=4'b1111, remainder=dividend.

Structure
REQ-026 SHALL place the state encoding, the width constant (4), the iteration count (4) and the divide-by-zero quotient constant in shared package div4_pkg.
REQ-027 SHALL instantiate exactly one sub-module, div4_trial_sub: a combinational 5-bit subtractor returning the difference and a non-negative flag.

Verification
REQ-028 SHALL check: dividend=7, divisor=2 -> quotient=3, remainder=1; done high 5 cycles after start; busy high for the 5 cycles before it.
REQ-029 SHALL check: dividend=-7, divisor=2 -> quotient=4'b1101 (-3), remainder=4'b1111 (-1); and dividend=7, divisor=-2 -> quotient=-3, remainder=1.
REQ-030 SHALL check: dividend=5, divisor=0 -> done after 1 cycle, div_zero=1, quotient=4'b1111, remainder=4'b0101, busy never high.
REQ-031 SHALL check: dividend=-8, divisor=-1 -> quotient=4'b1000, overflow=1; dividend=-8, divisor=3 -> quotient=-2, remainder=-2, overflow=0.
REQ-032 SHALL check: a second start with 6/3 pulsed 2 cycles into the 7/2 operation -> ignored, result 3 r 1; then 6/3 started immediately after done -> 2 r 0.
REQ-033 SHALL check: rst asserted in the 3rd CALC cycle -> no done pulse, all outputs 0 on the next cycle, and a following 9/4 -> 2 r 1.
